// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Decoupled instruction fetch front-end. Owns the fetch PC and issues word
//   requests to instruction memory over req/gnt with in-order rvalid returns.
//   Returned words and their PCs are held in an in-order queue, which the
//   decode stage pops with a valid/ready handshake. A redirect flushes the
//   queue, restarts fetch at the new PC, and marks every return still in
//   flight for discard.
//
//   Optional build macro FETCH_BYPASS_EN: when the queue is empty and no
//   returns are being discarded, a returning word is presented to the
//   consumer in the same cycle. If the consumer takes it, the word is never
//   written into the queue.
//
//   Invariants: count + pending <= DEPTH, and drop <= pending.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [31:0]                imem_rdata_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);  // queue pointer width
  localparam int CW = AW + 1;         // occupancy / credit counter width
  localparam int SW = CW + 1;         // count + pending without overflow

  // Architectural state
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   ret_pc_reg,   ret_pc_next;
  logic [CW-1:0] count_reg,    count_next;
  logic [CW-1:0] pending_reg,  pending_next;
  logic [CW-1:0] drop_reg,     drop_next;
  logic [AW-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg,   wr_ptr_next;

  // Queue storage: word and PC per entry, no reset needed since occupancy
  // is tracked separately.
  logic [31:0] word_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  // Control terms
  logic [SW-1:0] inflight_sum;
  logic          has_credit;
  logic          grant;
  logic          ret_valid;
  logic          ret_drop;
  logic          ret_keep;
  logic          queue_empty;
  logic          bypass_hit;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign queue_empty     = (count_reg == '0);

  // Credit covers both buffered entries and requests that will still return,
  // so an accepted request always has a free slot waiting for it.
  assign inflight_sum = {1'b0, count_reg} + {1'b0, pending_reg};
  assign has_credit   = (inflight_sum < SW'(DEPTH));
  assign imem_req_o   = !rst_i && !redirect_i && has_credit;
  assign imem_addr_o  = fetch_pc_reg;
  assign grant        = imem_req_o && imem_gnt_i;

  // A stray rvalid with nothing outstanding is ignored so it cannot corrupt
  // the counters; the assertion below flags it in simulation.
  assign ret_valid = imem_rvalid_i && (pending_reg != '0);
  assign ret_drop  = ret_valid && (drop_reg != '0);
  assign ret_keep  = ret_valid && (drop_reg == '0) && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = ret_keep && queue_empty;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit && instr_ready_i;

  // A pop during a redirect is ignored: the whole queue is flushed anyway.
  assign pop  = !queue_empty && instr_ready_i && !redirect_i;
  assign push = ret_keep && !bypass_take;

  // Consumer-facing head: queue head when non-empty, otherwise the bypassed
  // return (bypass builds only), otherwise zeros.
  always_comb begin
    instr_valid_o = !queue_empty || bypass_hit;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (!queue_empty) begin
      instr_o    = word_mem[rd_ptr_reg];
      instr_pc_o = pc_mem[rd_ptr_reg];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass_hit) begin
      instr_o    = imem_rdata_i;
      instr_pc_o = ret_pc_reg;
    end
`endif
  end

  assign count_o = count_reg;

  // Next-state: redirect overrides everything; otherwise grants, returns,
  // pushes and pops update their own counters independently.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    ret_pc_next   = ret_pc_reg;
    count_next    = count_reg;
    pending_next  = pending_reg;
    drop_next     = drop_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;

    if (redirect_i) begin
      // Every outstanding request except one returning right now will come
      // back stale; the current return is discarded as well.
      fetch_pc_next = redirect_target;
      ret_pc_next   = redirect_target;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      pending_next  = pending_reg - CW'(ret_valid);
      drop_next     = pending_reg - CW'(ret_valid);
    end else begin
      if (grant) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      pending_next = pending_reg + CW'(grant) - CW'(ret_valid);
      if (ret_drop) begin
        drop_next = drop_reg - CW'(1);
      end
      // Return PC advances for every kept word, bypassed or queued.
      if (ret_keep) begin
        ret_pc_next = ret_pc_reg + 32'd4;
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_reg <= RESET_PC;
      ret_pc_reg   <= RESET_PC;
      count_reg    <= '0;
      pending_reg  <= '0;
      drop_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      ret_pc_reg   <= ret_pc_next;
      count_reg    <= count_next;
      pending_reg  <= pending_next;
      drop_reg     <= drop_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  // Queue write port: kept returns land at the tail with their PC.
  always_ff @(posedge clk_i) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= imem_rdata_i;
      pc_mem[wr_ptr_reg]   <= ret_pc_reg;
    end
  end

  // Memory must never return data that was not requested.
  a_no_stray_rvalid: assert property (
    @(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && (pending_reg == '0))
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Randomized bench for instr_fetch_queue. A memory responder returns the
//   words for granted addresses in order, at least one cycle after grant.
//   A queue-level reference model (list of buffered {pc,word}, counts of
//   outstanding and to-be-discarded returns) predicts every output each
//   cycle. Honors FETCH_BYPASS_EN the same way the design does.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = '0;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_gnt_i = 1'b0;
  logic          imem_rvalid_i = 1'b0;
  logic [31:0]   imem_rdata_i = '0;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic          instr_ready_i = 1'b0;
  logic [CW-1:0] count_o;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // Reference model state
  entry_t      m_queue[$];
  int unsigned m_pending;
  int unsigned m_drop;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_ret_pc;

  // Memory responder: addresses granted and not yet returned, in order
  logic [31:0] mem_outstanding[$];

  // Stimulus knobs (percent)
  int p_gnt, p_rv, p_ready, p_redir;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  // Deterministic instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_queue.delete();
    m_pending  = 0;
    m_drop     = 0;
    m_fetch_pc = RESET_PC;
    m_ret_pc   = RESET_PC;
    mem_outstanding.delete();
  endtask

  // Assert reset part-way through a cycle and check the outputs respond
  // before any clock edge, then release it.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check({tag, "_req"},   32'(imem_req_o),    32'd0);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_count"}, 32'(count_o),       32'd0);
    check({tag, "_addr"},  imem_addr_o,        RESET_PC);
    check({tag, "_instr"}, instr_o,            32'd0);
    check({tag, "_pc"},    instr_pc_o,         32'd0);
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] pick_redirect_pc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0:       return 32'h0000_0100 | {30'd0, r[1:0]};
      1:       return 32'hFFFF_FFF0 | {28'd0, r[3:0]};
      default: return r & 32'h0000_0FFF;
    endcase
  endfunction

  // One cycle: drive random inputs, compare outputs with the model, then
  // advance the model across the clock edge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      bit          exp_req, exp_valid, byp, grant, rv, took;
      logic [31:0] exp_word, exp_pc, rdata;

      @(negedge clk);
      redirect_i    = ($urandom_range(99) < p_redir);
      redirect_pc_i = pick_redirect_pc();
      imem_gnt_i    = ($urandom_range(99) < p_gnt);
      rv            = (mem_outstanding.size() > 0) && ($urandom_range(99) < p_rv);
      rdata         = rv ? mem_word(mem_outstanding[0]) : $urandom;
      imem_rvalid_i = rv;
      imem_rdata_i  = rdata;
      instr_ready_i = ($urandom_range(99) < p_ready);
      #1;

      exp_req = !redirect_i && (m_queue.size() + m_pending < DEPTH);
      byp = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp = (m_queue.size() == 0) && (m_drop == 0) && rv && !redirect_i;
`endif
      exp_valid = (m_queue.size() > 0) || byp;
      check("req",   32'(imem_req_o),    32'(exp_req));
      check("addr",  imem_addr_o,        m_fetch_pc);
      check("valid", 32'(instr_valid_o), 32'(exp_valid));
      check("count", 32'(count_o),       32'(m_queue.size()));
      if (exp_valid) begin
        exp_word = (m_queue.size() > 0) ? m_queue[0].word : rdata;
        exp_pc   = (m_queue.size() > 0) ? m_queue[0].pc   : m_ret_pc;
        check("instr",    instr_o,    exp_word);
        check("instr_pc", instr_pc_o, exp_pc);
      end

      @(posedge clk);
      grant = exp_req && imem_gnt_i;
      if (rv) void'(mem_outstanding.pop_front());
      if (grant) mem_outstanding.push_back(m_fetch_pc);

      if (redirect_i) begin
        m_queue.delete();
        m_pending  = m_pending - (rv ? 1 : 0);
        m_drop     = m_pending;
        m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
        m_ret_pc   = m_fetch_pc;
        $display("[TB] redirect to %h", m_fetch_pc);
      end else begin
        took = 1'b0;
        if (m_queue.size() > 0 && instr_ready_i) begin
          entry_t e;
          e = m_queue.pop_front();
          n_pops++;
          $display("[TB] pop pc=%h word=%h", e.pc, e.word);
        end
        if (grant) begin
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_pending++;
        end
        if (rv) begin
          m_pending--;
          if (m_drop > 0) begin
            m_drop--;
          end else begin
            if (byp && instr_ready_i) begin
              took = 1'b1;
              n_pops++;
              $display("[TB] bypass pc=%h word=%h", m_ret_pc, rdata);
            end
            if (!took) m_queue.push_back('{pc: m_ret_pc, word: rdata});
            m_ret_pc = m_ret_pc + 32'd4;
          end
        end
      end
    end
  endtask

  task automatic set_rates(input int g, input int r, input int rd, input int rx);
    p_gnt = g; p_rv = r; p_ready = rd; p_redir = rx;
  endtask

  initial begin
    model_reset();
    set_rates(0, 0, 0, 0);
    apply_reset("reset");

    // Steady stream: every request granted, returns as early as allowed
    set_rates(100, 100, 100, 0);
    run_cycles(40);

    // Fill: consumer stalled, queue saturates at DEPTH and req drops
    set_rates(100, 100, 0, 0);
    run_cycles(20);
    check("full_count", 32'(count_o), DEPTH);
    // Single pop frees exactly one credit
    set_rates(100, 100, 100, 0);
    run_cycles(1);
    set_rates(100, 100, 0, 0);
    run_cycles(8);

    // Grant stall: address must hold
    set_rates(0, 100, 100, 0);
    run_cycles(6);
    set_rates(0, 0, 100, 0);
    run_cycles(3);

    // Redirect-heavy traffic with slow returns
    set_rates(100, 30, 60, 15);
    run_cycles(300);

    // Mid-stream asynchronous reset
    set_rates(80, 60, 50, 5);
    run_cycles(25);
    apply_reset("midreset");

    // Broad random mix
    for (int k = 0; k < 6; k++) begin
      set_rates($urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(0, 100), $urandom_range(0, 10));
      run_cycles(250);
    end

    if (n_pops == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL no_progress: got 0 instructions consumed expected >0");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
